da2_serial_tx: RTL and testbench

//   Serial transmitter for the PmodDA2 dual 12-bit DAC (two DAC121S101 devices) on port JB.
//   - Answers the dacdav/davdac four-phase handshake driven by the filter/generator controllers.
//   - Frames one 16-bit word per channel: {2'b00, daccmd, dacdata}, MSB first.
//   - Both channels share dacsync and dacsck; each channel has its own data line (JB2, JB3).
//   - Runs on the 25 MHz sysclk; the controller runs on the slower genclk.

---
 rtl/da2_serial_tx.sv | 164 ++++++++++++++++
 tb/tb_da2_serial_tx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da2_serial_tx.sv
// Serial transmitter for the PmodDA2 dual DAC: answers the dacdav/davdac handshake and
// shifts one {2'b00, daccmd, sample} word per channel, MSB first, on shared sync/sck lines.
module da2_serial_tx #(
  parameter int CLKDIV = 1,
  parameter int QUIET  = 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        dacdav,
  output logic        davdac,
  input  logic [1:0]  daccmd,
  input  logic [11:0] dacdata_a,
  input  logic [11:0] dacdata_b,
  output logic        dacsync,
  output logic        dacsck,
  output logic        dacout_a,
  output logic        dacout_b
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_QUIET = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] DIV_LAST   = 4'(CLKDIV - 1);
  localparam logic [3:0] QUIET_LAST = 4'(QUIET - 1);
  localparam logic [3:0] BIT_LAST   = 4'd15;

  logic       dav_meta_reg;
  logic       dav_s_reg;

  logic [1:0] state_reg, state_next;
  logic [3:0] div_reg, div_next;
  logic [3:0] bit_reg, bit_next;
  logic [3:0] quiet_reg, quiet_next;
  logic       sck_reg, sck_next;
  logic       sync_reg, sync_next;
  logic       davdac_reg, davdac_next;
  logic       load;
  logic       advance;

  logic [11:0] sample [2];
  logic [1:0]  dout;

  // dacdav comes from the slower genclk domain
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      dav_meta_reg <= 1'b0;
      dav_s_reg    <= 1'b0;
    end else begin
      dav_meta_reg <= dacdav;
      dav_s_reg    <= dav_meta_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    div_next    = div_reg;
    bit_next    = bit_reg;
    quiet_next  = quiet_reg;
    sck_next    = sck_reg;
    sync_next   = sync_reg;
    davdac_next = davdac_reg;
    load        = 1'b0;
    advance     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (dav_s_reg && !davdac_reg) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
          sync_next  = 1'b0;
          sck_next   = 1'b1;
          div_next   = 4'd0;
          bit_next   = 4'd0;
        end
      end
      ST_SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next = 4'd0;
          if (sck_reg) begin
            sck_next = 1'b0;
          end else begin
            // End of a bit period: rising sck either presents the next bit or closes the frame
            sck_next = 1'b1;
            if (bit_reg == BIT_LAST) begin
              state_next = ST_QUIET;
              sync_next  = 1'b1;
              quiet_next = 4'd0;
            end else begin
              bit_next = bit_reg + 4'd1;
              advance  = 1'b1;
            end
          end
        end else begin
          div_next = div_reg + 4'd1;
        end
      end
      ST_QUIET: begin
        if (quiet_reg == QUIET_LAST) begin
          state_next  = ST_DONE;
          davdac_next = 1'b1;
        end else begin
          quiet_next = quiet_reg + 4'd1;
        end
      end
      ST_DONE: begin
        if (!dav_s_reg) begin
          davdac_next = 1'b0;
          state_next  = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      div_reg    <= 4'd0;
      bit_reg    <= 4'd0;
      quiet_reg  <= 4'd0;
      sck_reg    <= 1'b1;
      sync_reg   <= 1'b1;
      davdac_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      div_reg    <= div_next;
      bit_reg    <= bit_next;
      quiet_reg  <= quiet_next;
      sck_reg    <= sck_next;
      sync_reg   <= sync_next;
      davdac_reg <= davdac_next;
    end
  end

  assign sample[0] = dacdata_a;
  assign sample[1] = dacdata_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [15:0] shift_reg;

    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        shift_reg <= 16'd0;
      end else if (load) begin
        shift_reg <= {2'b00, daccmd, sample[gi]};
      end else if (advance) begin
        shift_reg <= {shift_reg[14:0], 1'b0};
      end
    end

    // Data line is forced low whenever no frame is in progress
    assign dout[gi] = shift_reg[15] & ~sync_reg;
  end

  assign dacout_a = dout[0];
  assign dacout_b = dout[1];
  assign dacsync  = sync_reg;
  assign dacsck   = sck_reg;
  assign davdac   = davdac_reg;

endmodule

// File: tb/tb_da2_serial_tx.sv
// Bench for da2_serial_tx: table-driven frames, handshake corner cases and a randomized
// controller loop, with frames reconstructed from the DAC-side sync/sck/data lines.
module tb_da2_serial_tx;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        dacdav = 1'b0;
  logic [1:0]  daccmd = 2'b00;
  logic [11:0] dacdata_a = 12'h000;
  logic [11:0] dacdata_b = 12'h000;

  logic davdac1, dacsync1, dacsck1, dacout_a1, dacout_b1;
  logic davdac3, dacsync3, dacsck3, dacout_a3, dacout_b3;

  da2_serial_tx #(.CLKDIV(1), .QUIET(2)) dut (
    .sysclk(sysclk), .reset(reset), .dacdav(dacdav), .davdac(davdac1),
    .daccmd(daccmd), .dacdata_a(dacdata_a), .dacdata_b(dacdata_b),
    .dacsync(dacsync1), .dacsck(dacsck1), .dacout_a(dacout_a1), .dacout_b(dacout_b1)
  );

  da2_serial_tx #(.CLKDIV(3), .QUIET(2)) dut3 (
    .sysclk(sysclk), .reset(reset), .dacdav(dacdav), .davdac(davdac3),
    .daccmd(daccmd), .dacdata_a(dacdata_a), .dacdata_b(dacdata_b),
    .dacsync(dacsync3), .dacsck(dacsck3), .dacout_a(dacout_a3), .dacout_b(dacout_b3)
  );

  always #20 sysclk = ~sysclk;

  typedef struct {
    logic [15:0] wa;
    logic [15:0] wb;
    int          nb;
    int          low;
    int          fall_c;
    int          rise_c;
  } frame_t;

  typedef struct {
    logic [1:0]  cmd;
    logic [11:0] da;
    logic [11:0] db;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge sysclk) cyc <= cyc + 1;

  // DAC-side monitor: index 0 watches the CLKDIV=1 instance, index 1 the CLKDIV=3 instance
  logic [1:0] sync_v, sck_v, oa_v, ob_v, dav_v;
  assign sync_v = {dacsync3, dacsync1};
  assign sck_v  = {dacsck3, dacsck1};
  assign oa_v   = {dacout_a3, dacout_a1};
  assign ob_v   = {dacout_b3, dacout_b1};
  assign dav_v  = {davdac3, davdac1};

  frame_t q0[$];
  frame_t q1[$];
  logic        m_act [2] = '{1'b0, 1'b0};
  logic        m_ps  [2] = '{1'b1, 1'b1};
  logic        m_pk  [2] = '{1'b1, 1'b1};
  logic        m_pd  [2] = '{1'b0, 1'b0};
  logic [15:0] m_wa  [2];
  logic [15:0] m_wb  [2];
  int          m_nb  [2] = '{0, 0};
  int          m_low [2] = '{0, 0};
  int          m_fall[2] = '{0, 0};
  int          dav_rise[2] = '{0, 0};
  frame_t      mon_r;

  always @(negedge sysclk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_act[k] = 1'b0;
        m_ps[k]  = 1'b1;
        m_pk[k]  = 1'b1;
        m_pd[k]  = 1'b0;
        continue;
      end
      if (m_ps[k] && !sync_v[k]) begin
        m_act[k] = 1'b1; m_wa[k] = 16'h0; m_wb[k] = 16'h0;
        m_nb[k] = 0; m_low[k] = 0; m_fall[k] = cyc;
      end
      if (!sync_v[k]) begin
        m_low[k]++;
        if (m_pk[k] && !sck_v[k]) begin
          m_wa[k] = {m_wa[k][14:0], oa_v[k]};
          m_wb[k] = {m_wb[k][14:0], ob_v[k]};
          m_nb[k]++;
        end
      end
      if (!m_ps[k] && sync_v[k] && m_act[k]) begin
        mon_r.wa = m_wa[k]; mon_r.wb = m_wb[k]; mon_r.nb = m_nb[k];
        mon_r.low = m_low[k]; mon_r.fall_c = m_fall[k]; mon_r.rise_c = cyc;
        if (k == 0) q0.push_back(mon_r);
        else q1.push_back(mon_r);
        m_act[k] = 1'b0;
      end
      if (!m_pd[k] && dav_v[k]) dav_rise[k] = cyc;
      m_ps[k] = sync_v[k];
      m_pk[k] = sck_v[k];
      m_pd[k] = dav_v[k];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic wait_dav(input int k, input logic val, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sysclk);
      if (dav_v[k] == val) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic wait_bits(input int nbits);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sysclk);
      if (m_act[0] && m_nb[0] >= nbits) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_bits_reached", int'(ok), 1);
  endtask

  task automatic pop_frame(input int k, output frame_t r);
    int sz;
    sz = (k == 0) ? q0.size() : q1.size();
    chk("frame_available", int'(sz > 0), 1);
    r = '{16'h0, 16'h0, 0, 0, 0, 0};
    if (sz > 0) r = (k == 0) ? q0.pop_front() : q1.pop_front();
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic set_inputs(input logic [1:0] c, input logic [11:0] a, input logic [11:0] b);
    daccmd = c;
    dacdata_a = a;
    dacdata_b = b;
  endtask

  vec_t   vecs[4];
  frame_t fr;
  int     t0;
  int     viol;
  int     sent;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [1:0]  rc;
  logic [11:0] ra, rb;

  initial begin
    vecs[0] = '{2'b00, 12'hA5C, 12'h3F0, 16'h0A5C, 16'h03F0};
    vecs[1] = '{2'b01, 12'h000, 12'hFFF, 16'h1000, 16'h1FFF};
    vecs[2] = '{2'b10, 12'h801, 12'h001, 16'h2801, 16'h2001};
    vecs[3] = '{2'b11, 12'h555, 12'hAAA, 16'h3555, 16'h3AAA};

    // Reset state
    repeat (3) @(negedge sysclk);
    chk("reset_dacsync", int'(dacsync1), 1);
    chk("reset_dacsck", int'(dacsck1), 1);
    chk("reset_dacout", int'({dacout_a1, dacout_b1}), 0);
    chk("reset_davdac", int'({davdac1, davdac3}), 0);
    chk("reset_dut3_lines", int'({dacsync3, dacsck3, dacout_a3, dacout_b3}), 4'b1100);
    reset = 1'b0;
    q0.delete();
    q1.delete();

    // Table-driven frames on the CLKDIV=1 instance
    for (int v = 0; v < 4; v++) begin
      @(negedge sysclk);
      set_inputs(vecs[v].cmd, vecs[v].da, vecs[v].db);
      dacdav = 1'b1;
      t0 = cyc;
      wait_dav(0, 1'b1, 200, "vec_davdac_rise");
      @(negedge sysclk);
      pop_frame(0, fr);
      chk("vec_word_a", int'(fr.wa), int'(vecs[v].ea));
      chk("vec_word_b", int'(fr.wb), int'(vecs[v].eb));
      chk("vec_bits", fr.nb, 16);
      chk("vec_sync_low", fr.low, 32);
      chk("vec_dav_to_sync", fr.fall_c - t0, 3);
      chk("vec_sync_to_davdac", dav_rise[0] - fr.rise_c, 2);
      dacdav = 1'b0;
      wait_dav(0, 1'b0, 3, "vec_davdac_fall");
    end

    // Hold dacdav high after completion: no re-trigger
    @(negedge sysclk);
    set_inputs(vecs[0].cmd, vecs[0].da, vecs[0].db);
    dacdav = 1'b1;
    wait_dav(0, 1'b1, 200, "hold_davdac_rise");
    viol = 0;
    repeat (200) begin
      @(negedge sysclk);
      if (!davdac1 || !dacsync1) viol++;
    end
    chk("hold_violations", viol, 0);
    chk("hold_single_frame", q0.size(), 1);
    q0.delete();
    dacdav = 1'b0;
    wait_dav(0, 1'b0, 3, "hold_davdac_fall");
    @(negedge sysclk);
    set_inputs(vecs[1].cmd, vecs[1].da, vecs[1].db);
    dacdav = 1'b1;
    wait_dav(0, 1'b1, 200, "second_davdac_rise");
    pop_frame(0, fr);
    chk("second_word_a", int'(fr.wa), 16'h1000);
    dacdav = 1'b0;
    wait_dav(0, 1'b0, 3, "second_davdac_fall");

    // CLKDIV=3 instance
    do_reset();
    set_inputs(2'b11, 12'hFFF, 12'h5A5);
    dacdav = 1'b1;
    t0 = cyc;
    wait_dav(1, 1'b1, 400, "div3_davdac_rise");
    @(negedge sysclk);
    pop_frame(1, fr);
    chk("div3_word_a", int'(fr.wa), 16'h3FFF);
    chk("div3_word_b", int'(fr.wb), 16'h35A5);
    chk("div3_bits", fr.nb, 16);
    chk("div3_sync_low", fr.low, 96);
    chk("div3_dav_to_sync", fr.fall_c - t0, 3);
    chk("div3_sync_to_davdac", dav_rise[1] - fr.rise_c, 2);
    dacdav = 1'b0;
    wait_dav(1, 1'b0, 5, "div3_davdac_fall");

    // Data change mid-frame is not seen until the next handshake
    do_reset();
    set_inputs(2'b00, 12'h123, 12'h456);
    dacdav = 1'b1;
    wait_bits(8);
    dacdata_a = 12'hABC;
    wait_dav(0, 1'b1, 200, "midchg_davdac_rise");
    pop_frame(0, fr);
    chk("midchg_word_a", int'(fr.wa), 16'h0123);
    chk("midchg_word_b", int'(fr.wb), 16'h0456);
    dacdav = 1'b0;
    wait_dav(0, 1'b0, 3, "midchg_davdac_fall");
    @(negedge sysclk);
    dacdav = 1'b1;
    wait_dav(0, 1'b1, 200, "midchg2_davdac_rise");
    pop_frame(0, fr);
    chk("midchg2_word_a", int'(fr.wa), 16'h0ABC);
    dacdav = 1'b0;
    wait_dav(0, 1'b0, 3, "midchg2_davdac_fall");

    // Asynchronous reset at bit 7, then a clean frame
    do_reset();
    set_inputs(2'b10, 12'h7E1, 12'h18E);
    dacdav = 1'b1;
    wait_bits(7);
    #5 reset = 1'b1;
    #1;
    chk("abort_lines", int'({dacsync1, dacsck1, dacout_a1, dacout_b1, davdac1}), 5'b11000);
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    wait_dav(0, 1'b1, 200, "abort_davdac_rise");
    pop_frame(0, fr);
    chk("abort_word_a", int'(fr.wa), 16'h27E1);
    chk("abort_word_b", int'(fr.wb), 16'h218E);
    chk("abort_bits", fr.nb, 16);
    chk("abort_sync_low", fr.low, 32);
    dacdav = 1'b0;
    wait_dav(0, 1'b0, 3, "abort_davdac_fall");

    // Randomized controller on a 500 kHz genclk (one step per 2000 ns)
    do_reset();
    sent = 0;
    for (int step = 0; step < 400; step++) begin
      #2000;
      if (!dacdav && !davdac1) begin
        if (sent == 50) break;
        rc = 2'($urandom_range(0, 3));
        ra = 12'($urandom);
        rb = 12'($urandom);
        set_inputs(rc, ra, rb);
        exp_a.push_back({2'b00, rc, ra});
        exp_b.push_back({2'b00, rc, rb});
        dacdav = 1'b1;
        sent++;
      end else if (dacdav && davdac1) begin
        dacdav = 1'b0;
      end
    end
    chk("ctrl_all_sent", sent, 50);
    chk("ctrl_frame_count", q0.size(), exp_a.size());
    while (q0.size() > 0 && exp_a.size() > 0) begin
      fr = q0.pop_front();
      chk("ctrl_word_a", int'(fr.wa), int'(exp_a.pop_front()));
      chk("ctrl_word_b", int'(fr.wb), int'(exp_b.pop_front()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
